sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL provide parameter DATA_W, default 8, memory data width.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide per requester k in {0,1} these ports:
- reqk  input  1  request; held high until ackk.
- wek  input  1  1 = write, 0 = read.
- addrk  input  ADDR_W  target address.
- wdatak  input  DATA_W  write data.
- ackk  output  1  one-cycle completion pulse.
- rdatak  output  DATA_W  read data.
REQ-006 SHALL provide these memory-side ports:
- mem_cs_n  output  1  chip select, active-low.
- mem_oe_n  output  1  output enable, active-low.
- mem_we_n  output  1  write enable, active-low.
- mem_addr  output  ADDR_W  memory address.
- mem_data  inout  DATA_W  bidirectional memory data bus.
REQ-007 SHALL provide port busy  output  1  high in every state except IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, WR, RD1, RD2, DONE.
REQ-009 SHALL, in IDLE with at least one reqk high at a rising edge, grant one requester, latch its we/addr/wdata, and enter WR (we=1) or RD1 (we=0).
REQ-010 SHALL resolve a tie (both req high in IDLE) round-robin: grant the requester not granted last.
REQ-011 SHALL grant a lone requester regardless of the last grant.
REQ-012 SHALL drive outputs from registered state only.
REQ-013 SHALL, in WR, drive mem_cs_n=0, mem_we_n=0, mem_oe_n=1, mem_addr=latched address, and mem_data=latched wdata; WR lasts exactly one cycle, then DONE.
REQ-014 SHALL, in RD1 and RD2, drive mem_cs_n=0, mem_oe_n=0, mem_we_n=1, mem_addr=latched address, and mem_data=Z.
REQ-015 SHALL go RD1 -> RD2 unconditionally, and at the end of RD2 capture mem_data into rdatak of the granted requester, then enter DONE.
REQ-016 SHALL, in DONE, pulse ackk of the granted requester for exactly one cycle, ignore all requests, and return to IDLE.
REQ-017 SHALL, in IDLE and DONE, drive mem_cs_n=mem_oe_n=mem_we_n=1 and mem_data=Z.
REQ-018 SHALL drive mem_data only in WR; never in the same cycle as mem_oe_n=0.
REQ-019 SHALL produce latency, counted from the cycle reqk is first seen in IDLE: write ack at +2 cycles, read ack at +3 cycles.
REQ-020 SHALL hold rdatak until the next read completion for that requester; write completions leave rdatak unchanged.
REQ-021 SHALL ignore changes on reqk/wek/addrk/wdatak after the grant until DONE.
REQ-022 SHALL never assert ack0 and ack1 in the same cycle.
REQ-023 SHALL, when the requester ignores the ack and keeps reqk high, treat it as a new request in the following IDLE.

Reset
REQ-024 SHALL, while rst=1, immediately (without waiting for a clock edge) force IDLE; mem_cs_n=mem_oe_n=mem_we_n=1; mem_data=Z; ack0=ack1=0; busy=0; rdata0=rdata1=0; mem_addr=0; last-grant set so requester 0 wins the first tie.
REQ-025 SHALL, on rst asserted mid-transaction, abandon the transaction without ack; a write aborted before the end of WR is not guaranteed to reach memory.

Verification
REQ-026 SHALL cover reset: rst=1 during RD2 -> outputs return to idle values the same cycle, no ack; after release, req0 read completes normally.
REQ-027 SHALL cover write: req0 write addr=0x1234 data=0xA5 at cycle N -> mem_cs_n=mem_we_n=0 only in N+1 with mem_data=0xA5; ack0 in N+2.
REQ-028 SHALL cover read: after REQ-027, req0 read 0x1234 at cycle M -> mem_oe_n=0 in M+1..M+2; ack0 in M+3; rdata0=0xA5.
REQ-029 SHALL cover tie: req0 and req1 both high from reset release -> requester 0 served first, then 1; with both held continuously, grants alternate 0,1,0,1.
REQ-030 SHALL cover a lone requester: req1 only, writes 0x0000=0x11 then 0xFFFF=0x22, then reads both -> four consecutive grants to requester 1; rdata1=0x11 then 0x22; ack0 never asserted.
REQ-031 SHALL cover bus contention: across all scenarios, mem_data driven by the arbiter never coincides with mem_oe_n=0 (assertion check).

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port asynchronous SRAM.
// One transaction at a time, round-robin on ties; every output is a register.
module sram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_cs_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, DONE} state_t;

  state_t            state;
  logic              gnt;
  logic              last_gnt;
  logic              pick;
  logic              drive_data;
  logic [DATA_W-1:0] wdata_q;

  // Tie goes to whoever was not served last; a lone request always wins.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last_gnt;
  end

  assign mem_data = drive_data ? wdata_q : 'z;

  // Memory strobes are set on entry to each state so they come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_gnt   <= 1'b1;
      wdata_q    <= '0;
      drive_data <= 1'b0;
      mem_cs_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_we_n   <= 1'b1;
      mem_addr   <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt      <= pick;
            last_gnt <= pick;
            mem_addr <= pick ? addr1 : addr0;
            wdata_q  <= pick ? wdata1 : wdata0;
            busy     <= 1'b1;
            mem_cs_n <= 1'b0;
            if (pick ? we1 : we0) begin
              state      <= WR;
              mem_we_n   <= 1'b0;
              drive_data <= 1'b1;
            end else begin
              state    <= RD1;
              mem_oe_n <= 1'b0;
            end
          end
        end
        WR: begin
          state      <= DONE;
          mem_cs_n   <= 1'b1;
          mem_we_n   <= 1'b1;
          drive_data <= 1'b0;
          if (gnt) ack1 <= 1'b1;
          else     ack0 <= 1'b1;
        end
        RD1: begin
          state <= RD2;
        end
        RD2: begin
          state    <= DONE;
          mem_cs_n <= 1'b1;
          mem_oe_n <= 1'b1;
          if (gnt) begin
            rdata1 <= mem_data;
            ack1   <= 1'b1;
          end else begin
            rdata0 <= mem_data;
            ack0   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM on the shared bus.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we  = '0;
  logic [15:0] addr  [2];
  logic [7:0]  wdata [2];
  logic        ack0, ack1;
  logic [7:0]  rdata0, rdata1;
  logic        mem_cs_n, mem_oe_n, mem_we_n;
  logic [15:0] mem_addr;
  wire  [7:0]  mem_data;
  logic        busy;

  logic [7:0]  mem [0:65535];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ack0_cnt = 0;
  int unsigned overlap = 0;
  int unsigned contention = 0;
  int unsigned ack0_base;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]), .ack0(ack0), .rdata0(rdata0),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]), .ack1(ack1), .rdata1(rdata1),
    .mem_cs_n(mem_cs_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
  );

  assign mem_data = (!mem_cs_n && !mem_oe_n && mem_we_n) ? mem[mem_addr] : 'z;

  always @(posedge clk) begin
    if (!mem_cs_n && !mem_we_n) mem[mem_addr] <= mem_data;
  end

  always @(negedge clk) begin
    if (ack0) ack0_cnt++;
    if (ack0 && ack1) overlap++;
    if (dut.drive_data && !mem_oe_n) contention++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends in an IDLE cycle; requester k issues one op and drops req on ack.
  task automatic run_op(input int k, input logic w, input logic [15:0] a,
                        input logic [7:0] d, input logic [7:0] r);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    check("op_idle_busy", busy, 0);
    step();
    check("op_cs_n", mem_cs_n, 0);
    check("op_addr", mem_addr, a);
    check("op_we_n", mem_we_n, !w);
    check("op_oe_n", mem_oe_n, w);
    if (w) check("op_wdata", mem_data, d);
    else begin
      step();
      check("op_rd2_oe_n", mem_oe_n, 0);
    end
    step();
    check("op_ack", k ? ack1 : ack0, 1);
    check("op_other_ack", k ? ack0 : ack1, 0);
    if (!w) check("op_rdata", k ? rdata1 : rdata0, r);
    req[k] = 1'b0;
    step();
    check("op_ack_drop", k ? ack1 : ack0, 0);
    check("op_busy_drop", busy, 0);
  endtask

  initial begin
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_cs_n", mem_cs_n, 1);
    check("rst_oe_n", mem_oe_n, 1);
    check("rst_we_n", mem_we_n, 1);
    check("rst_busy", busy, 0);
    check("rst_acks", {ack1, ack0}, 0);
    check("rst_rdata", {rdata1, rdata0}, 0);
    check("rst_addr", mem_addr, 0);
    step(); step();
    rst = 1'b0;

    // write 0x1234 = 0xA5
    run_op(0, 1'b1, 16'h1234, 8'hA5, 8'h00);
    check("mem_1234", mem[16'h1234], 8'hA5);

    // read back; inputs change after grant and must be ignored
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h1234; wdata[0] = 8'h5A;
    check("rd_idle_oe_n", mem_oe_n, 1);
    step();
    check("rd1_oe_n", mem_oe_n, 0);
    check("rd1_cs_n", mem_cs_n, 0);
    check("rd1_we_n", mem_we_n, 1);
    check("rd1_addr", mem_addr, 16'h1234);
    check("rd1_ack0", ack0, 0);
    addr[0] = 16'h0000; we[0] = 1'b1;
    step();
    check("rd2_oe_n", mem_oe_n, 0);
    check("rd2_addr", mem_addr, 16'h1234);
    check("rd2_ack0", ack0, 0);
    step();
    check("rd_ack0", ack0, 1);
    check("rd_rdata0", rdata0, 8'hA5);
    check("rd_done_oe_n", mem_oe_n, 1);
    req[0] = 1'b0; we[0] = 1'b0; addr[0] = 16'h1234;
    step();
    check("rd_ack0_drop", ack0, 0);
    check("rd_rdata0_hold", rdata0, 8'hA5);

    // reset asserted during RD2
    req[0] = 1'b1;
    step();
    step();
    check("mid_rd2_oe_n", mem_oe_n, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_oe_n", mem_oe_n, 1);
    check("mid_rst_cs_n", mem_cs_n, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdata0", rdata0, 0);
    check("mid_rst_addr", mem_addr, 0);
    step();
    check("mid_rst_ack0", ack0, 0);
    rst = 1'b0;
    step();
    check("post_rst_rd1", mem_oe_n, 0);
    step();
    step();
    check("post_rst_ack0", ack0, 1);
    check("post_rst_rdata0", rdata0, 8'hA5);
    req[0] = 1'b0;
    step();
    check("post_rst_ack0_drop", ack0, 0);

    // tie from reset release, both held: grants 0,1,0,1
    rst = 1'b1;
    req = 2'b11; we = 2'b11;
    addr[0] = 16'h0010; wdata[0] = 8'h01;
    addr[1] = 16'h0020; wdata[1] = 8'h02;
    step();
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      check("tie_idle_busy", busy, 0);
      step();
      check("tie_addr", mem_addr, (g % 2 == 0) ? 32'h0010 : 32'h0020);
      step();
      check("tie_ack0", ack0, (g % 2 == 0) ? 1 : 0);
      check("tie_ack1", ack1, (g % 2 == 0) ? 0 : 1);
      step();
    end
    req = '0;
    check("tie_mem0", mem[16'h0010], 8'h01);
    check("tie_mem1", mem[16'h0020], 8'h02);

    // lone requester 1 after it was just served
    step();
    ack0_base = ack0_cnt;
    run_op(1, 1'b1, 16'h0000, 8'h11, 8'h00);
    run_op(1, 1'b1, 16'hFFFF, 8'h22, 8'h00);
    run_op(1, 1'b0, 16'h0000, 8'h00, 8'h11);
    run_op(1, 1'b0, 16'hFFFF, 8'h00, 8'h22);
    check("lone_no_ack0", ack0_cnt - ack0_base, 0);

    check("ack_overlap", overlap, 0);
    check("bus_contention", contention, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
